// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with bus lock in front of data_memory

module dmem_arbiter #(
    parameter int MEM_SIZE = 1024,
    parameter int LOCK_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_lock,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata
);

    localparam int               CNT_W      = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_MAX - 1);
    localparam logic [32:0]      ADDR_LIMIT = 33'(MEM_SIZE) * 33'd4;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             prio, prio_next;          // 0: m0 wins a tie, 1: m1 wins a tie
    logic [CNT_W-1:0] lock_cnt, lock_cnt_next;

    // Response side: one outstanding read at most, tagged with its owner
    logic             rd_pend;
    logic             rd_id;
    logic             err0_q, err1_q;
    logic [31:0]      raddr_hold;

    logic             acc0, acc1, acc;
    logic             sel_id;
    logic             sel_we;
    logic             sel_lock;
    logic [31:0]      sel_addr;
    logic [31:0]      sel_wdata;
    logic             sel_err;
    logic             rd_issue;

    // Grant: round-robin in ARB, owner-only while locked, nothing during reset
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            case (state)
                ARB: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = ~prio;
                        m1_gnt = prio;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                LOCK0:   m0_gnt = m0_req;
                LOCK1:   m1_gnt = m1_req;
                default: ;
            endcase
        end
    end

    // Select the accepted transaction (grants are mutually exclusive) and check its address
    always_comb begin
        acc0      = m0_req & m0_gnt;
        acc1      = m1_req & m1_gnt;
        acc       = acc0 | acc1;
        sel_id    = acc1;
        sel_we    = acc1 ? m1_we    : m0_we;
        sel_lock  = acc1 ? m1_lock  : m0_lock;
        sel_addr  = acc1 ? m1_addr  : m0_addr;
        sel_wdata = acc1 ? m1_wdata : m0_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= ADDR_LIMIT);
        rd_issue  = acc & ~sel_we & ~sel_err;
    end

    // Memory port drive: erroring accesses never reach the memory
    always_comb begin
        mem_we    = acc & sel_we & ~sel_err;
        mem_waddr = sel_addr;
        mem_wdata = sel_wdata;
        mem_raddr = rd_issue ? sel_addr : raddr_hold;
    end

    // Next state, priority rotation and lock timeout
    always_comb begin
        state_next    = state;
        prio_next     = prio;
        lock_cnt_next = lock_cnt;
        if (acc) begin
            prio_next = ~sel_id;
        end
        case (state)
            ARB: begin
                if (acc && sel_lock) begin
                    state_next    = sel_id ? LOCK1 : LOCK0;
                    lock_cnt_next = '0;
                end
            end
            LOCK0, LOCK1: begin
                // The counter runs every locked cycle so an idle owner cannot starve the other port
                lock_cnt_next = lock_cnt + 1'b1;
                if (lock_cnt == LOCK_LAST) begin
                    state_next    = ARB;
                    prio_next     = (state == LOCK0);
                    lock_cnt_next = '0;
                end else if (acc && !sel_lock) begin
                    state_next    = ARB;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ARB;
                lock_cnt_next = '0;
            end
        endcase
    end

    // State register and response pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            prio       <= 1'b0;
            lock_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_id      <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            raddr_hold <= '0;
        end else begin
            state      <= state_next;
            prio       <= prio_next;
            lock_cnt   <= lock_cnt_next;
            rd_pend    <= rd_issue;
            rd_id      <= sel_id;
            err0_q     <= acc0 & sel_err;
            err1_q     <= acc1 & sel_err;
            raddr_hold <= mem_raddr;
        end
    end

    // Route the read data to its owner; a reset asserted mid-flight drops the response at once
    always_comb begin
        m0_rvalid = rd_pend & ~rd_id & ~rst;
        m1_rvalid = rd_pend &  rd_id & ~rst;
        m0_rdata  = m0_rvalid ? mem_rdata : 32'h0;
        m1_rdata  = m1_rvalid ? mem_rdata : 32'h0;
        m0_err    = err0_q & ~rst;
        m1_err    = err1_q & ~rst;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:1023];

    dmem_arbiter #(.MEM_SIZE(1024), .LOCK_MAX(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_lock   (m0_lock),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory: independent write port, registered read port
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr[11:2]] <= mem_wdata;
        mem_rdata <= mem[mem_raddr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[1]    = 32'h0000_0001;
        mem[2]    = 32'hA5A5_0002;
        mem[1023] = 32'hDEAD_BEEF;
        mem_rdata = 32'h0;
        idle();
        rst = 1;

        // Reset: requests are ignored, no memory write, no responses
        next_cycle();
        next_cycle();
        m0_req = 1; m0_we = 1; m0_addr = 32'h8; m1_req = 1;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_err", m1_err, 0);
        idle();
        next_cycle();
        rst = 0;

        // Test 1: single read of preloaded word 1
        m0_req = 1; m0_addr = 32'h4;
        #1;
        chk("t1_m0_gnt", m0_gnt, 1);
        chk("t1_m1_gnt", m1_gnt, 0);
        chk("t1_raddr", mem_raddr, 32'h4);
        next_cycle();
        m0_req = 0;
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata", m0_rdata, 32'h1);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        next_cycle();
        chk("t1_rvalid_gone", m0_rvalid, 0);
        chk("t1_rdata_zero", m0_rdata, 0);

        // Test 2: both read continuously from reset, grants alternate
        rst = 1;
        next_cycle();
        rst = 0;
        m0_req = 1; m0_addr = 32'h4;
        m1_req = 1; m1_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_m0_gnt", m0_gnt, (k % 2 == 0));
            chk("t2_m1_gnt", m1_gnt, (k % 2 == 1));
            next_cycle();
            chk("t2_m0_rvalid", m0_rvalid, (k % 2 == 0));
            chk("t2_m1_rvalid", m1_rvalid, (k % 2 == 1));
            chk("t2_rdata", (k % 2 == 0) ? m0_rdata : m1_rdata,
                (k % 2 == 0) ? 32'h0000_0001 : 32'hA5A5_0002);
        end
        idle();

        // Test 3: m1 writes 0xC, m0 reads it back the next cycle
        m1_req = 1; m1_we = 1; m1_addr = 32'hC; m1_wdata = 32'h1;
        #1;
        chk("t3_m1_gnt", m1_gnt, 1);
        chk("t3_mem_we", mem_we, 1);
        chk("t3_waddr", mem_waddr, 32'hC);
        chk("t3_wdata", mem_wdata, 32'h1);
        next_cycle();
        idle();
        chk("t3_no_wr_rvalid", m1_rvalid, 0);
        m0_req = 1; m0_addr = 32'hC;
        #1;
        chk("t3_m0_gnt", m0_gnt, 1);
        next_cycle();
        idle();
        chk("t3_m0_rvalid", m0_rvalid, 1);
        chk("t3_m0_rdata", m0_rdata, 32'h1);

        // Priority now with m1; a lone m1 read hands it back to m0
        m1_req = 1; m1_addr = 32'h8;
        next_cycle();
        idle();

        // Test 4: m0 holds the lock for 3 accesses, unlocks on the 4th; m1 stalls meanwhile
        m1_req = 1; m1_addr = 32'h8;
        m0_req = 1; m0_addr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            m0_lock = (k < 3);
            #1;
            chk("t4_m0_gnt", m0_gnt, 1);
            chk("t4_m1_gnt", m1_gnt, 0);
            next_cycle();
        end
        m0_req = 0; m0_lock = 0;
        #1;
        chk("t4_m1_gnt_after", m1_gnt, 1);
        next_cycle();
        idle();
        chk("t4_m1_rvalid", m1_rvalid, 1);
        chk("t4_m1_rdata", m1_rdata, 32'hA5A5_0002);

        // Test 5: forced release after LOCK_MAX=4 idle locked cycles
        m0_req = 1; m0_lock = 1; m0_addr = 32'h4;
        m1_req = 1; m1_addr = 32'h8;
        #1;
        chk("t5_m0_gnt", m0_gnt, 1);
        next_cycle();
        m0_req = 0; m0_lock = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_m1_stalled", m1_gnt, 0);
            next_cycle();
        end
        #1;
        chk("t5_m1_gnt_release", m1_gnt, 1);
        next_cycle();
        idle();

        // Test 6: out-of-range and misaligned writes, then the last valid word
        m0_req = 1; m0_we = 1; m0_addr = 32'h1000; m0_wdata = 32'h1234_5678;
        #1;
        chk("t6_gnt_oor", m0_gnt, 1);
        chk("t6_we_oor", mem_we, 0);
        next_cycle();
        chk("t6_err_oor", m0_err, 1);
        chk("t6_rvalid_oor", m0_rvalid, 0);
        m0_addr = 32'h6;
        #1;
        chk("t6_we_mis", mem_we, 0);
        next_cycle();
        chk("t6_err_mis", m0_err, 1);
        m0_we = 0; m0_addr = 32'hFFC;
        next_cycle();
        idle();
        chk("t6_err_edge", m0_err, 0);
        chk("t6_rvalid_edge", m0_rvalid, 1);
        chk("t6_rdata_edge", m0_rdata, 32'hDEAD_BEEF);
        chk("t6_mem_unchanged", mem[0], 32'h0);

        // Reset during an in-flight read discards the response
        m0_req = 1; m0_addr = 32'h4;
        next_cycle();
        idle();
        rst = 1;
        #1;
        chk("t6_rst_rvalid", m0_rvalid, 0);
        chk("t6_rst_rdata", m0_rdata, 0);
        next_cycle();
        chk("t6_rst_rvalid2", m0_rvalid, 0);
        chk("t6_rst_raddr", mem_raddr, 0);
        rst = 0;
        m0_req = 1; m1_req = 1;
        #1;
        chk("t6_post_m0_gnt", m0_gnt, 1);
        chk("t6_post_m1_gnt", m1_gnt, 0);
        idle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
